seq_alu: RTL and testbench

- Parametrised, multicycle successor to the datapath's combinational ALU.
- Single-cycle ops (move/not/add/sub/or/and/xor/slt) complete in 1 clock. Shifts iterate one bit per clock; multiply is shift-add, one bit per clock.
- Start/busy/done handshake lets the multicycle CPU control FSM stall in its EXECUTE state until the result is ready.
- Result and flags are registered and held until the next completion.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 149 ++++++++++++++
 tb/tb_seq_alu.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Operand/result bundle between the CPU control path and seq_alu.
// The master side issues requests; the slave side (the ALU) returns status and result.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             overflow;

    modport master (
        output start, op_code, a, b,
        input  busy, done, out, zero, overflow
    );

    modport slave (
        input  start, op_code, a, b,
        output busy, done, out, zero, overflow
    );
endinterface

// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle logic/arith ops, bit-serial shifts and shift-add multiply.
// Result and flags are registered on entry to DONE and held until the next completion.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    seq_alu_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_MOV = 4'b0000;
    localparam logic [3:0] OP_NOT = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b1011;

    logic [1:0]       state;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] out_r;
    logic             zero_r;
    logic             ovf_r;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ovf;
    logic               iter_op;
    logic [WIDTH-1:0]   step_work;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   run_res;

    // Result for ops that finish on the accepting edge, computed from live inputs.
    always_comb begin
        shamt   = bus.b[SHAMT_W-1:0];
        sum     = bus.a + bus.b;
        diff    = bus.a - bus.b;
        sc_res  = '0;
        sc_ovf  = 1'b0;
        iter_op = 1'b0;
        case (bus.op_code)
            OP_MOV: sc_res = bus.a;
            OP_NOT: sc_res = ~bus.a;
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_OR:  sc_res = bus.a | bus.b;
            OP_AND: sc_res = bus.a & bus.b;
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_XOR: sc_res = bus.a ^ bus.b;
            OP_SLL, OP_SRL, OP_SRA: begin
                // A zero shift amount completes immediately with the operand unchanged.
                sc_res  = bus.a;
                iter_op = (shamt != '0);
            end
            OP_MUL: iter_op = 1'b1;
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        step_work = work;
        case (op_r)
            OP_SLL, OP_MUL: step_work = work << 1;
            OP_SRL:         step_work = work >> 1;
            OP_SRA:         step_work = {work[WIDTH-1], work[WIDTH-1:1]};
            default:        step_work = work;
        endcase
        acc_next = mplr[0] ? (acc + work) : acc;
        run_res  = (op_r == OP_MUL) ? acc_next : step_work;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_r   <= '0;
            work   <= '0;
            mplr   <= '0;
            acc    <= '0;
            cnt    <= '0;
            out_r  <= '0;
            zero_r <= 1'b1;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_r <= bus.op_code;
                        work <= bus.a;
                        mplr <= bus.b;
                        acc  <= '0;
                        if (iter_op) begin
                            state <= S_RUN;
                            cnt   <= (bus.op_code == OP_MUL) ? CNT_W'(WIDTH) : {1'b0, shamt};
                        end else begin
                            state  <= S_DONE;
                            out_r  <= sc_res;
                            zero_r <= (sc_res == '0);
                            ovf_r  <= sc_ovf;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    work <= step_work;
                    mplr <= mplr >> 1;
                    acc  <= acc_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= S_DONE;
                        out_r  <= run_res;
                        zero_r <= (run_res == '0);
                        ovf_r  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == S_RUN);
    assign bus.done     = (state == S_DONE);
    assign bus.out      = out_r;
    assign bus.zero     = zero_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: latency, results, flags, handshake and reset abort.
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) bus ();
    seq_alu_if #(.WIDTH(8))  bus8 ();

    seq_alu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    seq_alu #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 32-bit DUT; lat=1 means done seen in the cycle right after the accepting edge.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input bit toggle,
                          output int lat, output int busy_n);
        logic [31:0] prev;
        bit          hold_checked;
        prev = bus.out;
        hold_checked = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op_code = op; bus.a = av; bus.b = bv;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 1;
        busy_n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.done) break;
            if (bus.busy) begin
                busy_n++;
                if (!hold_checked) begin
                    chk({tag, "_hold"}, bus.out, prev);
                    hold_checked = 1'b1;
                end
            end
            if (toggle) begin
                if (lat >= 2 && lat <= 10) begin
                    bus.start = lat[0];
                    bus.a = $urandom;
                    bus.b = $urandom;
                    bus.op_code = 4'($urandom_range(0, 15));
                end else begin
                    bus.start = 1'b0;
                end
            end
            if (lat > 200) begin
                chk({tag, "_timeout"}, {31'd0, bus.done}, 32'd1);
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        int  lat;
        int  bn;
        bit  seen;
        bus.start = 1'b0; bus.op_code = '0; bus.a = '0; bus.b = '0;
        bus8.start = 1'b0; bus8.op_code = '0; bus8.a = '0; bus8.b = '0;

        repeat (2) @(negedge clk);
        chk("rst_out", bus.out, 32'h0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, bn);
        chk("add_lat", lat, 1);
        chk("add_out", bus.out, 32'h8000_0000);
        chk("add_ovf", {31'd0, bus.overflow}, 32'd1);
        chk("add_zero", {31'd0, bus.zero}, 32'd0);
        @(negedge clk);
        chk("add_done_pulse", {31'd0, bus.done}, 32'd0);
        chk("add_held", bus.out, 32'h8000_0000);

        run_op("sub_zero", 4'b0011, 32'h1234, 32'h1234, 1'b0, lat, bn);
        chk("sub_out", bus.out, 32'h0);
        chk("sub_zero", {31'd0, bus.zero}, 32'd1);
        chk("sub_ovf", {31'd0, bus.overflow}, 32'd0);

        run_op("sub_ovf", 4'b0011, 32'h8000_0000, 32'h1, 1'b0, lat, bn);
        chk("subo_out", bus.out, 32'h7FFF_FFFF);
        chk("subo_ovf", {31'd0, bus.overflow}, 32'd1);

        run_op("or", 4'b0100, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, lat, bn);
        chk("or_out", bus.out, 32'hF0F0_0F0F);
        chk("or_ovf", {31'd0, bus.overflow}, 32'd0);
        run_op("and", 4'b0101, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, lat, bn);
        chk("and_out", bus.out, 32'h0F00_0F00);
        run_op("xor", 4'b1011, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, lat, bn);
        chk("xor_out", bus.out, 32'h5555_5555);
        run_op("slt", 4'b0110, 32'h3, 32'hFFFF_FFFF, 1'b0, lat, bn);
        chk("slt_out", bus.out, 32'h1);
        run_op("slt_ge", 4'b0110, 32'hFFFF_FFFF, 32'h3, 1'b0, lat, bn);
        chk("slt_ge_out", bus.out, 32'h0);
        chk("slt_ge_zero", {31'd0, bus.zero}, 32'd1);

        run_op("sll", 4'b0111, 32'h1, 32'h25, 1'b0, lat, bn);
        chk("sll_lat", lat, 6);
        chk("sll_busy", bn, 5);
        chk("sll_out", bus.out, 32'h20);

        run_op("sra", 4'b1001, 32'h8000_0000, 32'h4, 1'b0, lat, bn);
        chk("sra_lat", lat, 5);
        chk("sra_out", bus.out, 32'hF800_0000);

        run_op("srl", 4'b1000, 32'hF000_0000, 32'h4, 1'b0, lat, bn);
        chk("srl_out", bus.out, 32'h0F00_0000);

        run_op("srl0", 4'b1000, 32'hDEAD_BEEF, 32'h0, 1'b0, lat, bn);
        chk("srl0_lat", lat, 1);
        chk("srl0_out", bus.out, 32'hDEAD_BEEF);

        run_op("mul", 4'b1010, 32'h0001_0001, 32'h0001_0001, 1'b1, lat, bn);
        chk("mul_lat", lat, 33);
        chk("mul_busy", bn, 32);
        chk("mul_out", bus.out, 32'h0002_0001);
        chk("mul_ovf", {31'd0, bus.overflow}, 32'd0);

        run_op("mul2", 4'b1010, 32'hFFFF_FFFF, 32'h3, 1'b0, lat, bn);
        chk("mul2_out", bus.out, 32'hFFFF_FFFD);

        // Back-to-back: start held high through the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.op_code = 4'b0000; bus.a = 32'h5; bus.b = 32'h0;
        @(posedge clk);
        #1 bus.op_code = 4'b0001; bus.a = 32'h0;
        @(negedge clk);
        chk("b2b_done1", {31'd0, bus.done}, 32'd1);
        chk("b2b_out1", bus.out, 32'h5);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_done2", {31'd0, bus.done}, 32'd1);
        chk("b2b_out2", bus.out, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("b2b_idle", {31'd0, bus.done}, 32'd0);

        run_op("illegal", 4'b1111, 32'h1234_5678, 32'h9, 1'b0, lat, bn);
        chk("ill_lat", lat, 1);
        chk("ill_out", bus.out, 32'h0);
        chk("ill_zero", {31'd0, bus.zero}, 32'd1);
        chk("ill_ovf", {31'd0, bus.overflow}, 32'd0);

        @(negedge clk);
        bus8.start = 1'b1; bus8.op_code = 4'b0010; bus8.a = 8'h7F; bus8.b = 8'h01;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        @(negedge clk);
        chk("w8_done", {31'd0, bus8.done}, 32'd1);
        chk("w8_out", {24'd0, bus8.out}, 32'h80);
        chk("w8_ovf", {31'd0, bus8.overflow}, 32'd1);

        run_op("pre_rst", 4'b0000, 32'hCAFE_0001, 32'h0, 1'b0, lat, bn);
        chk("pre_rst_out", bus.out, 32'hCAFE_0001);
        @(negedge clk);
        bus.start = 1'b1; bus.op_code = 4'b1010; bus.a = 32'h3; bus.b = 32'h5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out", bus.out, 32'h0);
        chk("abort_zero", {31'd0, bus.zero}, 32'd1);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);

        run_op("post_rst", 4'b0010, 32'h2, 32'h3, 1'b0, lat, bn);
        chk("post_lat", lat, 1);
        chk("post_out", bus.out, 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
